router_fifo: RTL and testbench

- Output-side packet buffer of the 1x3 router. One instance per destination port.
- Sits directly downstream of the register stage. It consumes that stage's byte stream (header, payload, parity) with the lfd_state header tag.
- It is drained by the destination's read_enb.
- Each stored word carries a header flag. The block tracks the bytes remaining in the packet currently being read out, using the header's length field.

---
 rtl/router_fifo.sv | 112 +++++++++++
 tb/tb_router_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// router_fifo: per-destination output buffer of the 1x3 router.
// Stores {header_flag, byte} words written by the register stage and tracks
// how many bytes of the packet currently being read out are still pending.
// Optional build macro: ROUTER_FIFO_OCC_EN adds the 'occupancy' output port.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     read_enb,
  input  logic                     lfd_state,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
`ifdef ROUTER_FIFO_OCC_EN
  output logic [$clog2(DEPTH):0]   occupancy,
`endif
  output logic                     pkt_active
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [WIDTH-2:0] CNT_ONE = {{(WIDTH-2){1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-2:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH:0]   mem_q [DEPTH];
  logic [WIDTH:0]   mem_d [DEPTH];

  logic             do_wr;
  logic             do_rd;
  logic [WIDTH:0]   rd_word;

  // Status flags straight from the registered pointers.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // full/empty are judged before this cycle's transfers, so a read at
    // full frees no room for a same-cycle write, and vice versa at empty.
    do_wr = write_enb && !full;
    do_rd = read_enb && !empty;
  end

  // Next-state for pointers, storage, read data and the packet byte counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    mem_d    = mem_q;
    rd_word  = mem_q[rd_ptr_q[AW-1:0]];

    if (soft_reset) begin
      // Flush: storage contents are left alone, they become unreachable.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      dout_d   = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q[AW-1:0]] = {lfd_state, data_in};
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        dout_d   = rd_word[WIDTH-1:0];
        if (rd_word[WIDTH]) begin
          // Header: length field plus one parity byte; abandons any old packet.
          cnt_d = {1'b0, rd_word[WIDTH-1:2]} + CNT_ONE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end
  end

  // State registers with synchronous active-low reset clearing everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      mem_q    <= mem_d;
    end
  end

  // Output drive.
  always_comb begin
    data_out   = dout_q;
    pkt_active = (cnt_q != '0);
`ifdef ROUTER_FIFO_OCC_EN
    occupancy  = wr_ptr_q - rd_ptr_q;
`endif
  end

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed plus random stimulus for router_fifo, checked
// against a queue-based reference model of the buffer and packet counter.
module tb_router_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             soft_reset = 1'b0;
  logic             write_enb = 1'b0;
  logic             read_enb = 1'b0;
  logic             lfd_state = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             full, empty, pkt_active;
`ifdef ROUTER_FIFO_OCC_EN
  logic [4:0]       occupancy;
`endif

  router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
`ifdef ROUTER_FIFO_OCC_EN
    .occupancy(occupancy),
`endif
    .pkt_active(pkt_active)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {header, byte} words, the last byte read,
  // and the number of packet bytes still expected.
  logic [WIDTH:0]   m_q[$];
  logic [WIDTH-1:0] m_dout;
  int               m_cnt;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model on the edge, compare #1 later.
  task automatic cyc(input logic r, input logic srst, input logic we, input logic re,
                     input logic lfd, input logic [WIDTH-1:0] din);
    logic [WIDTH:0] w;
    logic was_full, was_empty;
    rst = r; soft_reset = srst; write_enb = we; read_enb = re;
    lfd_state = lfd; data_in = din;
    @(posedge clk);
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (!r || srst) begin
      m_q.delete(); m_dout = '0; m_cnt = 0;
    end else begin
      if (re && !was_empty) begin
        w = m_q.pop_front();
        m_dout = w[WIDTH-1:0];
        if (w[WIDTH]) m_cnt = int'(w[WIDTH-1:2]) + 1;
        else if (m_cnt > 0) m_cnt--;
      end
      if (we && !was_full) m_q.push_back({lfd, din});
    end
    #1;
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("pkt_active", 32'(pkt_active), 32'(m_cnt != 0));
`ifdef ROUTER_FIFO_OCC_EN
    chk("occupancy", 32'(occupancy), 32'(m_q.size()));
`endif
  endtask

  task automatic wr(input logic lfd, input logic [WIDTH-1:0] din);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, lfd, din);
  endtask

  task automatic rd();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic write_packet();
    wr(1'b1, 8'h0D);
    wr(1'b0, 8'h11);
    wr(1'b0, 8'h22);
    wr(1'b0, 8'h33);
    wr(1'b0, 8'h3F);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] stored[DEPTH];
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] pkt[5];
    pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h3F;
    m_dout = '0; m_cnt = 0;

    // Reset held low for two cycles.
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 8'h00);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_pkt", 32'(pkt_active), 32'd0);
    chk("rst_dout", 32'(data_out), 32'h00);

    // One packet written then read out in five cycles.
    write_packet();
    for (int i = 0; i < 5; i++) begin
      rd();
      chk("pkt_dout", 32'(data_out), 32'(pkt[i]));
      if (i == 0) chk("pkt_active_after_hdr", 32'(pkt_active), 32'd1);
    end
    chk("pkt_active_after_parity", 32'(pkt_active), 32'd0);
    chk("pkt_empty_end", 32'(empty), 32'd1);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < DEPTH; i++) begin
      stored[i] = 8'($urandom_range(0, 255));
      if (stored[i] == 8'hAA) stored[i] = 8'h5A;
      wr(1'b0, stored[i]);
    end
    chk("full_after_16", 32'(full), 32'd1);
    wr(1'b0, 8'hAA);
    for (int i = 0; i < DEPTH; i++) begin
      rd();
      chk("drain_byte", 32'(data_out), 32'(stored[i]));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Simultaneous read and write while full: read wins, write dropped.
    for (int i = 0; i < DEPTH; i++) begin
      stored[i] = 8'(i + 8'h80);
      wr(1'b0, stored[i]);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
    chk("simul_full_dout", 32'(data_out), 32'(stored[0]));
    chk("simul_full_cleared", 32'(full), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      rd();
      chk("simul_full_drain", 32'(data_out), 32'(stored[i]));
    end
    chk("simul_full_empty", 32'(empty), 32'd1);

    // Soft reset in the middle of a packet, with a read requested.
    write_packet();
    rd(); rd(); rd();
    chk("mid_pkt_active", 32'(pkt_active), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("srst_empty", 32'(empty), 32'd1);
    chk("srst_pkt", 32'(pkt_active), 32'd0);
    chk("srst_dout", 32'(data_out), 32'h00);

    // Simultaneous read and write while empty: write wins, read blocked.
    wr(1'b0, 8'hC3);
    rd();
    held = data_out;
    chk("pre_empty_dout", 32'(held), 32'hC3);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07);
    chk("simul_empty_dout_hold", 32'(data_out), 32'(held));
    chk("simul_empty_not_empty", 32'(empty), 32'd0);
    rd();
    chk("simul_empty_next_read", 32'(data_out), 32'h07);

    // Random traffic: headers with random lengths, occasional flushes/resets.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 99) < 55),
          ($urandom_range(0, 99) < 50),
          ($urandom_range(0, 5) == 0),
          8'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
